// File: rtl/phase_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// phase_ctrl_pkg
//   Shared definitions for the multicycle sequencer and its consumers (pc,
//   datapath): phase bit indices, sequencer state encodings and a helper that
//   maps a state onto its one-hot phase vector.
//
//   Phase vector layout (bit index):  f=0, r=1, x=2, m=3, w=4
// -----------------------------------------------------------------------------
package phase_ctrl_pkg;

  // Phase bit indices into the one-hot phase vector.
  localparam int unsigned PH_F = 0;
  localparam int unsigned PH_R = 1;
  localparam int unsigned PH_X = 2;
  localparam int unsigned PH_M = 3;
  localparam int unsigned PH_W = 4;

  // Sequencer state encodings (legacy-compatible constants).
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_IFWAIT = 3'd1;
  localparam logic [2:0] ST_F      = 3'd2;
  localparam logic [2:0] ST_R      = 3'd3;
  localparam logic [2:0] ST_X      = 3'd4;
  localparam logic [2:0] ST_M      = 3'd5;
  localparam logic [2:0] ST_W      = 3'd6;
  localparam logic [2:0] ST_HALT   = 3'd7;

  // One-hot phase vector driven while in a given state. States without an
  // instruction phase (IDLE, IFWAIT, HALT) map to all zero.
  function automatic logic [PH_W:0] phase_of(input logic [2:0] st);
    logic [PH_W:0] ph;
    ph = '0;
    case (st)
      ST_F:    ph[PH_F] = 1'b1;
      ST_R:    ph[PH_R] = 1'b1;
      ST_X:    ph[PH_X] = 1'b1;
      ST_M:    ph[PH_M] = 1'b1;
      ST_W:    ph[PH_W] = 1'b1;
      default: ph = '0;
    endcase
    return ph;
  endfunction

  // States in which a halt request is latched as pending: the window in which
  // an instruction is in flight but has not yet reached W.
  function automatic logic in_halt_window(input logic [2:0] st);
    return (st == ST_IFWAIT) || (st == ST_F) || (st == ST_R) ||
           (st == ST_X) || (st == ST_M);
  endfunction

endpackage

// File: rtl/phase_ctrl.sv
// -----------------------------------------------------------------------------
// phase_ctrl
//   Multicycle CPU sequencer. Produces the one-hot phase vector (f,r,x,m,w)
//   used by pc and the datapath, owns the instruction/data memory wait
//   handshakes, run/halt control and a retired-instruction counter.
//   phase[f] is high for exactly one cycle per instruction.
//
//   Optional feature macro: PHASE_SKIP_EN
//     defined   -> non-memory instructions go X -> W directly (no M phase)
//     undefined -> X always goes to M; non-memory M lasts one cycle
//
// Parameters
//   CNT_W     width of the retired-instruction counter (wraps modulo 2^CNT_W)
//
// Ports
//   clk       in   clock, all state updates on posedge
//   n_rst     in   synchronous active-low reset
//   run       in   start pulse, honoured only in IDLE or HALT
//   halt_req  in   halt after the current instruction completes
//   is_mem    in   decoded instruction is load/store (valid from R onward)
//   imem_ack  in   instruction memory data valid
//   dmem_ack  in   data memory access complete
//   phase     out  one-hot phase, all zero in IDLE/IFWAIT/HALT
//   imem_req  out  instruction fetch request (high throughout IFWAIT)
//   dmem_req  out  data access request (high in M for memory instructions)
//   halted    out  high in HALT
//   retired   out  count of completed W phases
//
// All outputs are registered: each is computed from the next state and
// loaded on the same edge as the state, so there is no input->output path.
// -----------------------------------------------------------------------------
module phase_ctrl
  import phase_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             run,
  input  logic             halt_req,
  input  logic             is_mem,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic [PH_W:0]    phase,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  logic [2:0] state;
  logic [2:0] state_d;
  logic       halt_pend;
  logic       halt_pend_d;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state;
    halt_pend_d = halt_pend;

    // A halt request while an instruction is in flight is remembered so the
    // instruction can finish through W before stopping.
    if (halt_req && in_halt_window(state)) begin
      halt_pend_d = 1'b1;
    end

    case (state)
      ST_IDLE: begin
        if (run) state_d = ST_IFWAIT;
      end

      ST_IFWAIT: begin
        if (imem_ack) state_d = ST_F;
      end

      ST_F: state_d = ST_R;

      ST_R: state_d = ST_X;

      ST_X: begin
`ifdef PHASE_SKIP_EN
        state_d = is_mem ? ST_M : ST_W;
`else
        state_d = ST_M;
`endif
      end

      ST_M: begin
        // Memory instructions wait for the data ack; others pass in one cycle.
        if (!is_mem || dmem_ack) state_d = ST_W;
      end

      ST_W: begin
        // A halt request in this very cycle takes priority over anything else.
        if (halt_req || halt_pend) state_d = ST_HALT;
        else                       state_d = ST_IFWAIT;
      end

      ST_HALT: begin
        if (run) begin
          state_d     = ST_IFWAIT;
          halt_pend_d = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state     <= ST_IDLE;
      halt_pend <= 1'b0;
      phase     <= '0;
      imem_req  <= 1'b0;
      dmem_req  <= 1'b0;
      halted    <= 1'b0;
      retired   <= '0;
    end else begin
      state     <= state_d;
      halt_pend <= halt_pend_d;
      phase     <= phase_of(state_d);
      imem_req  <= (state_d == ST_IFWAIT);
      // is_mem is stable from R onward, so sampling it on entry to (and while
      // staying in) M gives the request for the whole M wait.
      dmem_req  <= (state_d == ST_M) && is_mem;
      halted    <= (state_d == ST_HALT);
      if (state == ST_W) begin
        retired <= retired + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_phase_ctrl.sv
module tb_phase_ctrl;

  localparam int unsigned CW = 4;

`ifdef PHASE_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  // One-hot phase patterns, bit order f=0 .. w=4
  localparam logic [4:0] P0 = 5'b00000;
  localparam logic [4:0] PF = 5'b00001;
  localparam logic [4:0] PR = 5'b00010;
  localparam logic [4:0] PX = 5'b00100;
  localparam logic [4:0] PM = 5'b01000;
  localparam logic [4:0] PW = 5'b10000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          n_rst, run, halt_req, is_mem, imem_ack, dmem_ack;
  logic [4:0]    phase;
  logic          imem_req, dmem_req, halted;
  logic [CW-1:0] retired;

  phase_ctrl #(.CNT_W(CW)) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .run      (run),
    .halt_req (halt_req),
    .is_mem   (is_mem),
    .imem_ack (imem_ack),
    .dmem_ack (dmem_ack),
    .phase    (phase),
    .imem_req (imem_req),
    .dmem_req (dmem_req),
    .halted   (halted),
    .retired  (retired)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Expected outputs for the current cycle, produced by the trace model below
  logic [4:0]    e_phase;
  logic          e_imem, e_dmem, e_halt;
  logic [CW-1:0] e_ret;
  bit            hpend;

  // Running counts of cycles with given outputs high (observed from DUT)
  int unsigned n_imem = 0, n_f = 0, n_m = 0, n_dmem = 0;

  task automatic exp_cyc(input logic [4:0] ph, input logic ir, input logic dr, input logic h);
    e_phase = ph; e_imem = ir; e_dmem = dr; e_halt = h;
  endtask

  // Per-cycle compare of every DUT output against the model expectation
  task automatic cycle_cmp();
    checks++;
    if (phase !== e_phase || imem_req !== e_imem || dmem_req !== e_dmem ||
        halted !== e_halt || retired !== e_ret) begin
      errors++;
      $display("FAIL cycle @%0t: got phase=%b imem_req=%b dmem_req=%b halted=%b retired=%0d, expected %b %b %b %b %0d",
               $time, phase, imem_req, dmem_req, halted, retired,
               e_phase, e_imem, e_dmem, e_halt, e_ret);
    end
    if (imem_req)  n_imem++;
    if (phase[0])  n_f++;
    if (phase[3])  n_m++;
    if (dmem_req)  n_dmem++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Compare the current cycle at negedge, then advance past the next posedge
  task automatic step();
    @(negedge clk);
    cycle_cmp();
    @(posedge clk);
    #1;
  endtask

  // Trace model for one instruction starting in its first IFWAIT cycle.
  // idly: cycles before imem_ack; mem: load/store; ddly: cycles before dmem_ack;
  // hx: halt_req pulse in X; rw: run pulse in W; abort_m: M cycle to reset in (-1 none)
  task automatic do_instr(input int idly, input bit mem, input int ddly,
                          input bit hx, input bit rw, input int abort_m);
    for (int k = 0; k <= idly; k++) begin
      exp_cyc(P0, 1'b1, 1'b0, 1'b0);
      imem_ack = (k == idly);
      dmem_ack = (k != idly);            // stray data ack while fetching
      step();
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;
    exp_cyc(PF, 1'b0, 1'b0, 1'b0);
    imem_ack = 1'b1; run = 1'b1; is_mem = mem;  // stray ack and run, ignored
    step();
    imem_ack = 1'b0; run = 1'b0;
    exp_cyc(PR, 1'b0, 1'b0, 1'b0);
    step();
    exp_cyc(PX, 1'b0, 1'b0, 1'b0);
    halt_req = hx;
    if (hx) hpend = 1'b1;
    step();
    halt_req = 1'b0;
    if (mem) begin
      for (int k = 0; k <= ddly; k++) begin
        exp_cyc(PM, 1'b0, 1'b1, 1'b0);
        dmem_ack = (k == ddly);
        if (k == abort_m) begin
          n_rst = 1'b0; dmem_ack = 1'b0;
          step();
          hpend = 1'b0; e_ret = '0;
          return;
        end
        step();
      end
      dmem_ack = 1'b0;
    end else if (!SKIP) begin
      exp_cyc(PM, 1'b0, 1'b0, 1'b0);
      step();
    end
    exp_cyc(PW, 1'b0, 1'b0, 1'b0);
    run = rw;
    step();
    run = 1'b0;
    e_ret = e_ret + CW'(1);
  endtask

  int unsigned s_imem, s_f, s_m, s_dmem;

  task automatic snap();
    s_imem = n_imem; s_f = n_f; s_m = n_m; s_dmem = n_dmem;
  endtask

  initial begin
    n_rst = 1'b0; run = 1'b0; halt_req = 1'b0; is_mem = 1'b0;
    imem_ack = 1'b0; dmem_ack = 1'b0; hpend = 1'b0;
    e_ret = '0;
    @(posedge clk); #1;
    exp_cyc(P0, 1'b0, 1'b0, 1'b0);
    step();                               // reset state
    chk("reset_retired", 32'(retired), 0);

    // Idle with halt_req (ignored), then run
    n_rst = 1'b1; halt_req = 1'b1;
    step();
    halt_req = 1'b0; run = 1'b1;
    step();
    run = 1'b0;

    // 1: immediate fetch ack, non-memory instruction
    snap();
    do_instr(0, 1'b0, 0, 1'b0, 1'b0, -1);
    chk("t1_retired", 32'(retired), 1);
    chk("t1_f_cycles", n_f - s_f, 1);
    chk("t1_m_cycles", n_m - s_m, SKIP ? 0 : 1);

    // 2: fetch ack delayed 3 cycles
    snap();
    do_instr(3, 1'b0, 0, 1'b0, 1'b0, -1);
    chk("t2_imem_cycles", n_imem - s_imem, 4);
    chk("t2_f_cycles", n_f - s_f, 1);

    // 3: memory instruction, dmem_ack after 4 cycles
    snap();
    do_instr(0, 1'b1, 4, 1'b0, 1'b0, -1);
    chk("t3_m_cycles", n_m - s_m, 5);
    chk("t3_dmem_cycles", n_dmem - s_dmem, 5);
    chk("t3_retired", 32'(retired), 3);

    // 4: halt pulse in X, run in W (halt wins), halt_req in HALT ignored
    do_instr(1, 1'b0, 0, 1'b1, 1'b1, -1);
    exp_cyc(P0, 1'b0, 1'b0, 1'b1);
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    chk("t4_halted", 32'(halted), 1);
    exp_cyc(P0, 1'b0, 1'b0, 1'b1);
    run = 1'b1; hpend = 1'b0;
    step();
    run = 1'b0;
    chk("t4_resume_halted", 32'(halted), 0);
    do_instr(1, 1'b0, 0, 1'b0, 1'b0, -1);
    chk("t4_no_rehalt", 32'(imem_req), 1);
    chk("t4_retired", 32'(retired), 5);

    // 5: reset during a memory wait
    do_instr(0, 1'b1, 5, 1'b0, 1'b0, 2);
    exp_cyc(P0, 1'b0, 1'b0, 1'b0);
    chk("t5_retired", 32'(retired), 0);
    chk("t5_dmem_req", 32'(dmem_req), 0);
    n_rst = 1'b1;
    step();
    run = 1'b1;
    step();
    run = 1'b0;

    // 6: fill the counter to its maximum, then wrap
    for (int i = 0; i < 15; i++) begin
      do_instr(i % 2, (i % 3) == 0, i % 3, 1'b0, 1'b0, -1);
    end
    chk("t6_retired_max", 32'(retired), 15);
    snap();
    do_instr(0, 1'b0, 0, 1'b0, 1'b0, -1);
    chk("t6_retired_wrap", 32'(retired), 0);
    chk("t6_m_cycles", n_m - s_m, SKIP ? 0 : 1);

    exp_cyc(P0, 1'b1, 1'b0, 1'b0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
